// File: rtl/tc_timer_if.sv
// ============================================================================
//  Module   : tc_timer_if
//  Purpose  : Core register bus and interrupt handshake between the CPU core
//             and the tc_timer peripheral.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tc_timer_if;
   logic       write;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       read;
   logic [7:0] rdata;
   logic       status_reg_interrupt_enable;
   logic       interrupt_request;
   logic       interrupt_executed;

   modport master (
      output write, addr, wdata, read, status_reg_interrupt_enable, interrupt_executed,
      input  rdata, interrupt_request
   );

   modport slave (
      input  write, addr, wdata, read, status_reg_interrupt_enable, interrupt_executed,
      output rdata, interrupt_request
   );
endinterface

`default_nettype wire

// File: rtl/tc_timer.sv
// ============================================================================
//  Module   : tc_timer
//  Purpose  : 8-bit timer/counter (normal and CTC modes) with two output-compare
//             units and an interrupt request/acknowledge handshake.
//             Define TC_EXT_CLK_EN to clock the counter from t0 edges (CS=6/7).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tc_timer #(
   parameter logic [7:0] IO_BASE    = 8'h24,
   parameter logic [7:0] MIRROR_OFS = 8'h20,
   parameter logic [7:0] A_TIFR     = 8'h15,
   parameter logic [7:0] A_TIMSK    = 8'h6E
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   tc_timer_if.slave   bus,
   input  wire logic   t0,
   output logic        oca_data,
   output logic        ocb_data
);

   localparam logic [7:0] C_A_TCCRA = IO_BASE;
   localparam logic [7:0] C_A_TCCRB = IO_BASE + 8'd1;
   localparam logic [7:0] C_A_TCNT  = IO_BASE + 8'd2;
   localparam logic [7:0] C_A_OCRA  = IO_BASE + 8'd3;
   localparam logic [7:0] C_A_OCRB  = IO_BASE + 8'd4;

   logic [1:0] r_coma, r_comb, r_wgm;
   logic       r_wgm2;
   logic [2:0] r_cs;
   logic [7:0] r_tcnt, r_ocra, r_ocrb;
   logic [2:0] r_timsk, r_tifr;
   logic [9:0] r_prescaler;
   logic       r_ack_d, r_irq;

   logic       w_sel_tccra, w_sel_tccrb, w_sel_tcnt, w_sel_ocra, w_sel_ocrb;
   logic       w_sel_tifr, w_sel_timsk;
   logic       w_tick, w_tcnt_wr, w_count, w_ctc;
   logic       w_match_a, w_match_b, w_tov_set, w_ack_rise;
   logic       w_t0_fall, w_t0_rise;
   logic [2:0] w_pending, w_ack_clr, w_tifr_wclr;
   logic [7:0] w_rdata;

   function automatic logic f_com_pin(input logic [1:0] com, input logic pin);
      case (com)
         2'b01:   f_com_pin = ~pin;
         2'b11:   f_com_pin = 1'b1;
         default: f_com_pin = 1'b0;
      endcase
   endfunction

   assign w_sel_tccra = (bus.addr == C_A_TCCRA) || (bus.addr == C_A_TCCRA + MIRROR_OFS);
   assign w_sel_tccrb = (bus.addr == C_A_TCCRB) || (bus.addr == C_A_TCCRB + MIRROR_OFS);
   assign w_sel_tcnt  = (bus.addr == C_A_TCNT)  || (bus.addr == C_A_TCNT  + MIRROR_OFS);
   assign w_sel_ocra  = (bus.addr == C_A_OCRA)  || (bus.addr == C_A_OCRA  + MIRROR_OFS);
   assign w_sel_ocrb  = (bus.addr == C_A_OCRB)  || (bus.addr == C_A_OCRB  + MIRROR_OFS);
   assign w_sel_tifr  = (bus.addr == A_TIFR)    || (bus.addr == A_TIFR    + MIRROR_OFS);
   assign w_sel_timsk = (bus.addr == A_TIMSK);

`ifdef TC_EXT_CLK_EN
   logic r_t0_meta, r_t0_sync, r_t0_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t0_meta <= 1'b0;
         r_t0_sync <= 1'b0;
         r_t0_prev <= 1'b0;
      end else begin
         r_t0_meta <= t0;
         r_t0_sync <= r_t0_meta;
         r_t0_prev <= r_t0_sync;
      end
   end

   assign w_t0_fall = r_t0_prev & ~r_t0_sync;
   assign w_t0_rise = ~r_t0_prev & r_t0_sync;
`else
   logic w_unused_t0;
   assign w_unused_t0 = t0;
   assign w_t0_fall   = 1'b0;
   assign w_t0_rise   = 1'b0;
`endif

   always_comb begin
      w_tick = 1'b0;
      case (r_cs)
         3'd1:    w_tick = 1'b1;
         3'd2:    w_tick = &r_prescaler[2:0];
         3'd3:    w_tick = &r_prescaler[5:0];
         3'd4:    w_tick = &r_prescaler[7:0];
         3'd5:    w_tick = &r_prescaler[9:0];
         3'd6:    w_tick = w_t0_fall;
         3'd7:    w_tick = w_t0_rise;
         default: w_tick = 1'b0;
      endcase
   end

   // A bus write to TCNT takes precedence and masks this cycle's compare match.
   assign w_tcnt_wr = bus.write & w_sel_tcnt;
   assign w_count   = w_tick & ~w_tcnt_wr;
   assign w_ctc     = ({r_wgm2, r_wgm} == 3'b010);
   assign w_match_a = w_count & (r_tcnt == r_ocra);
   assign w_match_b = w_count & (r_tcnt == r_ocrb);
   assign w_tov_set = w_count & (r_tcnt == 8'hFF) & (~w_ctc | (r_ocra == 8'hFF));

   // Acknowledge retires one flag at a time, OCFA first, then OCFB, then TOV.
   assign w_ack_rise = bus.interrupt_executed & ~r_ack_d;
   assign w_pending  = r_tifr & r_timsk;
   always_comb begin
      w_ack_clr = 3'b000;
      if (w_ack_rise) begin
         if (w_pending[1])      w_ack_clr = 3'b010;
         else if (w_pending[2]) w_ack_clr = 3'b100;
         else if (w_pending[0]) w_ack_clr = 3'b001;
      end
   end
   assign w_tifr_wclr = (bus.write && w_sel_tifr) ? bus.wdata[2:0] : 3'b000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_coma      <= 2'b00;
         r_comb      <= 2'b00;
         r_wgm       <= 2'b00;
         r_wgm2      <= 1'b0;
         r_cs        <= 3'b000;
         r_tcnt      <= 8'h00;
         r_ocra      <= 8'h00;
         r_ocrb      <= 8'h00;
         r_timsk     <= 3'b000;
         r_tifr      <= 3'b000;
         r_prescaler <= 10'd0;
         r_ack_d     <= 1'b1;
         r_irq       <= 1'b0;
         oca_data    <= 1'b0;
         ocb_data    <= 1'b0;
      end else begin
         r_prescaler <= r_prescaler + 10'd1;
         r_ack_d     <= bus.interrupt_executed;
         r_irq       <= bus.status_reg_interrupt_enable & (|(r_tifr & r_timsk));
         r_tifr      <= (r_tifr & ~w_tifr_wclr & ~w_ack_clr) | {w_match_b, w_match_a, w_tov_set};

         if (bus.write && w_sel_tccra) begin
            r_coma <= bus.wdata[7:6];
            r_comb <= bus.wdata[5:4];
            r_wgm  <= bus.wdata[1:0];
         end
         if (bus.write && w_sel_tccrb) begin
            r_wgm2 <= bus.wdata[3];
            r_cs   <= bus.wdata[2:0];
         end
         if (bus.write && w_sel_ocra)  r_ocra  <= bus.wdata;
         if (bus.write && w_sel_ocrb)  r_ocrb  <= bus.wdata;
         if (bus.write && w_sel_timsk) r_timsk <= bus.wdata[2:0];

         if (w_tcnt_wr)
            r_tcnt <= bus.wdata;
         else if (w_count)
            r_tcnt <= (w_ctc && (r_tcnt == r_ocra)) ? 8'h00 : r_tcnt + 8'd1;

         if (w_match_a) oca_data <= f_com_pin(r_coma, oca_data);
         if (w_match_b) ocb_data <= f_com_pin(r_comb, ocb_data);
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      if (bus.read) begin
         if (w_sel_tccra)      w_rdata = {r_coma, r_comb, 2'b00, r_wgm};
         else if (w_sel_tccrb) w_rdata = {4'b0000, r_wgm2, r_cs};
         else if (w_sel_tcnt)  w_rdata = r_tcnt;
         else if (w_sel_ocra)  w_rdata = r_ocra;
         else if (w_sel_ocrb)  w_rdata = r_ocrb;
         else if (w_sel_tifr)  w_rdata = {5'b00000, r_tifr};
         else if (w_sel_timsk) w_rdata = {5'b00000, r_timsk};
      end
   end

   assign bus.rdata             = w_rdata;
   assign bus.interrupt_request = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_tc_timer.sv
// ============================================================================
//  Module   : tb_tc_timer
//  Purpose  : Self-checking bench for tc_timer (register map, CTC timing,
//             compare/interrupt priority, prescaler, external clock, reset).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tc_timer;

   localparam logic [7:0] C_TCCRA  = 8'h24;
   localparam logic [7:0] C_TCCRB  = 8'h25;
   localparam logic [7:0] C_TCNT   = 8'h26;
   localparam logic [7:0] C_OCRA   = 8'h27;
   localparam logic [7:0] C_OCRB   = 8'h28;
   localparam logic [7:0] C_TIFR   = 8'h15;
   localparam logic [7:0] C_TIFR_M = 8'h35;
   localparam logic [7:0] C_TIMSK  = 8'h6E;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] alias_addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic t0 = 1'b0;
   logic oca, ocb;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   tc_timer_if bus();

   tc_timer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .t0       (t0),
      .oca_data (oca),
      .ocb_data (ocb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.write = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      bus.addr = a;
      bus.read = 1'b1;
      #1;
      d = bus.rdata;
   endtask

   task automatic ack();
      @(negedge clk);
      bus.interrupt_executed = 1'b1;
      @(negedge clk);
      bus.interrupt_executed = 1'b0;
   endtask

   task automatic run_ctc(input logic [7:0] ocra, input int cycles);
      int period;
      int last_chg;
      int last_irq;
      int nirq;
      logic [7:0] prev, cur;
      logic prev_irq, prev_oca;
      period   = (int'(ocra) + 1) * 8;
      last_chg = -1;
      last_irq = -1;
      nirq     = 0;
      wr(C_TCCRB, 8'h00);
      wr(C_TCCRA, 8'h42);
      wr(C_OCRA, ocra);
      wr(C_TIMSK, 8'h02);
      wr(C_TIFR, 8'h07);
      wr(C_TCNT, 8'h00);
      prev_oca = oca;
      prev_irq = bus.interrupt_request;
      prev     = 8'h00;
      wr(C_TCCRB, 8'h02);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         bus.interrupt_executed = 1'b0;
         rd(C_TCNT, cur);
         if (cur != prev) begin
            chk("ctc_seq", cur, (prev == ocra) ? 8'h00 : prev + 8'd1);
            if (last_chg >= 0) chk_int("ctc_step", cyc - last_chg, 8);
            last_chg = cyc;
            prev = cur;
         end
         if (bus.interrupt_request && !prev_irq) begin
            chk("oca_toggle", {7'd0, oca}, {7'd0, ~prev_oca});
            prev_oca = oca;
            if (last_irq >= 0) chk_int("irq_period", cyc - last_irq, period);
            last_irq = cyc;
            nirq++;
            bus.interrupt_executed = 1'b1;
         end
         prev_irq = bus.interrupt_request;
      end
      bus.interrupt_executed = 1'b0;
      chk_int("irq_seen", int'(nirq >= 2), 1);
   endtask

   task automatic sweep(input logic [2:0] cs, input int div);
      int t2, t3;
      logic [7:0] cur;
      t2 = -1;
      t3 = -1;
      wr(C_TCCRB, 8'h00);
      wr(C_TCCRA, 8'h02);
      wr(C_OCRA, 8'h18);
      wr(C_TCNT, 8'h00);
      wr(C_TCCRB, {5'd0, cs});
      for (int c = 0; c < 4 * div + 16; c++) begin
         @(negedge clk);
         rd(C_TCNT, cur);
         if (cur == 8'h02 && t2 < 0) t2 = cyc;
         if (cur == 8'h03 && t3 < 0) begin
            t3 = cyc;
            break;
         end
      end
      chk_int("presc_found", int'(t2 >= 0 && t3 >= 0), 1);
      if (t2 >= 0 && t3 >= 0) chk_int("presc_step", t3 - t2, div);
   endtask

   initial begin
      vec_t vecs[9];
      logic [7:0] d;
      int tb, ta, tirq, tb2;
      logic prev_irq;

      vecs[0] = '{C_TCCRA, C_TCCRA + 8'h20, 8'hFF, 8'hF3};
      vecs[1] = '{C_TCCRA, C_TCCRA + 8'h20, 8'h02, 8'h02};
      vecs[2] = '{C_TCCRB, C_TCCRB + 8'h20, 8'hF8, 8'h08};
      vecs[3] = '{C_OCRA,  C_OCRA  + 8'h20, 8'h05, 8'h05};
      vecs[4] = '{C_OCRB,  C_OCRB  + 8'h20, 8'h77, 8'h77};
      vecs[5] = '{C_TIMSK, C_TIMSK,         8'hFF, 8'h07};
      vecs[6] = '{C_TIMSK, C_TIMSK,         8'h07, 8'h07};
      vecs[7] = '{8'h50,   8'h50,           8'hAA, 8'h00};
      vecs[8] = '{C_TCCRB, C_TCCRB + 8'h20, 8'h02, 8'h02};

      bus.write = 1'b0;
      bus.read  = 1'b0;
      bus.addr  = 8'h00;
      bus.wdata = 8'h00;
      bus.status_reg_interrupt_enable = 1'b1;
      bus.interrupt_executed = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(C_TCNT, d);   chk("rst_tcnt", d, 8'h00);
      rd(C_TIFR, d);   chk("rst_tifr", d, 8'h00);
      rd(C_TCCRB, d);  chk("rst_tccrb", d, 8'h00);
      chk("rst_irq", {7'd0, bus.interrupt_request}, 8'h00);
      chk("rst_pins", {6'd0, oca, ocb}, 8'h00);

      for (int i = 0; i < 9; i++) begin
         wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, d);       chk("reg_base", d, vecs[i].exp);
         rd(vecs[i].alias_addr, d); chk("reg_alias", d, vecs[i].exp);
      end
      wr(C_TCCRB, 8'h00);
      bus.read = 1'b0;
      bus.addr = C_OCRB;
      #1 chk("read_gate", bus.rdata, 8'h00);

      run_ctc(8'h05, 160);
      run_ctc(8'h15, 560);

      // Priority: B then A 16 clk later, acks retire OCFA before OCFB
      wr(C_TCCRB, 8'h00);
      wr(C_TCCRA, 8'h02);
      wr(C_OCRA, 8'h18);
      wr(C_OCRB, 8'h16);
      wr(C_TIMSK, 8'h07);
      wr(C_TIFR, 8'h07);
      wr(C_TCNT, 8'h00);
      wr(C_TCCRB, 8'h02);
      tb = -1; ta = -1; tirq = -1;
      prev_irq = bus.interrupt_request;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rd(C_TIFR_M, d);
         if (d[2] && tb < 0) tb = cyc;
         if (bus.interrupt_request && !prev_irq && tirq < 0) tirq = cyc;
         prev_irq = bus.interrupt_request;
         if (d[1]) begin
            ta = cyc;
            break;
         end
      end
      chk_int("prio_found", int'(ta >= 0 && tb >= 0 && tirq >= 0), 1);
      chk_int("prio_a_after_b", ta - tb, 16);
      chk_int("prio_irq_lat", tirq - tb, 1);
      chk("prio_both", d, 8'h06);
      ack();
      rd(C_TIFR, d); chk("ack1_tifr", d, 8'h04);
      chk("ack1_irq", {7'd0, bus.interrupt_request}, 8'h01);
      ack();
      rd(C_TIFR, d); chk("ack2_tifr", d, 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("ack2_irq", {7'd0, bus.interrupt_request}, 8'h00);
      tb2 = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         rd(C_TIFR, d);
         if (d[2]) begin
            tb2 = cyc;
            break;
         end
      end
      chk_int("prio_period", tb2 - tb, 200);

      sweep(3'd3, 64);
      sweep(3'd4, 256);
      sweep(3'd5, 1024);

      // TCNT write masks a same-cycle match and beats the tick
      wr(C_TCCRB, 8'h00);
      wr(C_TIMSK, 8'h00);
      wr(C_TCCRA, 8'h00);
      wr(C_OCRA, 8'h10);
      wr(C_TCNT, 8'h10);
      wr(C_TIFR, 8'h07);
      @(negedge clk);
      bus.write = 1'b1; bus.addr = C_TCCRB; bus.wdata = 8'h01;
      @(negedge clk);
      bus.addr = C_TCNT; bus.wdata = 8'h80;
      @(negedge clk);
      bus.write = 1'b0;
      rd(C_TCNT, d); chk("wr_beats_tick", d, 8'h80);
      rd(C_TIFR, d); chk("wr_masks_match", d, 8'h00);
      wr(C_TCNT, 8'hFE);
      @(negedge clk);
      rd(C_TIFR, d); chk("tov_early", d, 8'h00);
      @(negedge clk);
      rd(C_TCNT, d); chk("wrap_tcnt", d, 8'h00);
      rd(C_TIFR, d); chk("tov_set", d, 8'h01);
      wr(C_TIFR, 8'h00);
      rd(C_TIFR, d); chk("tifr_w0_keeps", d, 8'h01);
      wr(C_TIFR, 8'h01);
      rd(C_TIFR, d); chk("tifr_w1_clears", d, 8'h00);

      // External clock on t0 falling edges
      wr(C_TCCRB, 8'h00);
      wr(C_TCNT, 8'h20);
      wr(C_TCCRB, 8'h06);
      for (int i = 0; i < 3; i++) begin
         t0 = 1'b1;
         repeat (4) @(negedge clk);
         t0 = 1'b0;
         repeat (4) @(negedge clk);
         rd(C_TCNT, d);
`ifdef TC_EXT_CLK_EN
         chk("ext_clk", d, 8'h21 + 8'(i));
`else
         chk("ext_clk", d, 8'h20);
`endif
      end
      rd(C_TCCRB, d); chk("cs_readback", d, 8'h06);

      // Reset mid-count
      wr(C_TCCRA, 8'hC0);
      wr(C_OCRA, 8'h00);
      wr(C_TCNT, 8'h00);
      wr(C_TCCRB, 8'h01);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      rd(C_TCNT, d); chk("midrst_tcnt", d, 8'h00);
      chk("midrst_oca", {7'd0, oca}, 8'h00);
      chk("midrst_irq", {7'd0, bus.interrupt_request}, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      rd(C_TCNT, d);  chk("midrst_hold", d, 8'h00);
      rd(C_TCCRB, d); chk("midrst_tccrb", d, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
